gen3_scrambler_ctrl: RTL and testbench

- Sequencing controller for one lane's Gen3 128b/130b 32-bit-per-beat LFSR scrambler.
- Tracks 130-bit block boundaries, four 32-bit beats per block, and decodes the block type from the sync header and ordered-set symbol 0.
- Drives the LFSR's seed value, seed-reload pulse, per-beat advance enable and per-byte scramble enable.
- Sits between the lane framing logic and the scrambler datapath.

---
 rtl/gen3_scrambler_ctrl.sv | 159 +++++++++++++++
 tb/tb_gen3_scrambler_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/gen3_scrambler_ctrl.sv
// rtl/gen3_scrambler_ctrl.sv - Gen3 128b/130b scrambler sequencing controller for one lane
// Tracks block/beat framing, decodes block type and drives LFSR seed/reload/advance/enables.
module gen3_scrambler_ctrl #(
  parameter int LANE_NUM = 0
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        gen3_en,
  input  logic        beat_valid,
  input  logic        block_start,
  input  logic [1:0]  sync_hdr,
  input  logic [7:0]  beat_sym0,
  output logic [23:0] seed_value,
  output logic        scrambler_reset,
  output logic        lfsr_advance,
  output logic [3:0]  scramble_en,
  output logic [2:0]  block_type,
  output logic [1:0]  beat_idx,
  output logic        sync_err
);

  localparam logic [2:0] BT_DATA  = 3'd0;
  localparam logic [2:0] BT_TS    = 3'd1;
  localparam logic [2:0] BT_SKP   = 3'd2;
  localparam logic [2:0] BT_EIEOS = 3'd3;
  localparam logic [2:0] BT_OS    = 3'd4;
  localparam logic [2:0] BT_NONE  = 3'd7;
  localparam int         SEED_SEL = LANE_NUM % 8;

  typedef enum logic {HUNT, IN_BLK} state_t;

  state_t      state, state_d;
  logic [1:0]  cnt_d;
  logic [2:0]  type_d;
  logic [2:0]  hdr_type;
  logic        hdr_bad;
  logic        err_d;
  logic        live;
  logic        adv_d;
  logic [3:0]  scr_d;
  logic        eieos_end_d;
  logic        reload_d;
  logic        reload_pend;
  logic        eieos_pend;
  logic        gen3_q;

  always_comb begin
    case (SEED_SEL)
      0:       seed_value = 24'h1DBFBC;
      1:       seed_value = 24'h0607BB;
      2:       seed_value = 24'h1EC760;
      3:       seed_value = 24'h18C0DB;
      4:       seed_value = 24'h010F12;
      5:       seed_value = 24'h19CFC9;
      6:       seed_value = 24'h0277CE;
      default: seed_value = 24'h1BB807;
    endcase
  end

  // Invalid sync headers are carried through as an unscrambled, advancing OS block.
  always_comb begin
    hdr_type = BT_OS;
    hdr_bad  = 1'b0;
    case (sync_hdr)
      2'b10: hdr_type = BT_DATA;
      2'b01: begin
        case (beat_sym0)
          8'h1E, 8'h2D: hdr_type = BT_TS;
          8'hAA:        hdr_type = BT_SKP;
          8'h00:        hdr_type = BT_EIEOS;
          default:      hdr_type = BT_OS;
        endcase
      end
      default: hdr_bad = 1'b1;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state      <= HUNT;
      beat_idx   <= 2'd0;
      block_type <= BT_NONE;
    end else begin
      state      <= state_d;
      beat_idx   <= cnt_d;
      block_type <= type_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = beat_idx;
    type_d  = block_type;
    err_d   = 1'b0;
    live    = 1'b0;
    if (!gen3_en) begin
      state_d = HUNT;
    end else if (beat_valid) begin
      if (block_start) begin
        state_d = IN_BLK;
        cnt_d   = 2'd0;
        type_d  = hdr_type;
        err_d   = hdr_bad | ((state == IN_BLK) && (beat_idx != 2'd3));
        live    = 1'b1;
      end else if (state == IN_BLK) begin
        if (beat_idx == 2'd3) begin
          err_d   = 1'b1;
          state_d = HUNT;
        end else begin
          cnt_d = beat_idx + 2'd1;
          live  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    adv_d = 1'b0;
    scr_d = 4'h0;
    if (live) begin
      case (type_d)
        BT_DATA: begin
          adv_d = 1'b1;
          scr_d = 4'hF;
        end
        BT_TS: begin
          adv_d = 1'b1;
          scr_d = (cnt_d == 2'd0) ? 4'hE : 4'hF;
        end
        BT_OS:   adv_d = 1'b1;
        default: adv_d = 1'b0;
      endcase
    end
    eieos_end_d = live && (type_d == BT_EIEOS) && (cnt_d == 2'd3);
    // Post-reset, EIEOS-end and gen3_en-rise reloads all merge into one pulse.
    reload_d    = reload_pend | eieos_pend | (gen3_en & ~gen3_q);
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      lfsr_advance    <= 1'b0;
      scramble_en     <= 4'h0;
      sync_err        <= 1'b0;
      scrambler_reset <= 1'b0;
      reload_pend     <= 1'b1;
      eieos_pend      <= 1'b0;
      gen3_q          <= 1'b0;
    end else begin
      lfsr_advance    <= adv_d;
      scramble_en     <= scr_d;
      sync_err        <= err_d;
      scrambler_reset <= reload_d;
      reload_pend     <= 1'b0;
      eieos_pend      <= eieos_end_d;
      gen3_q          <= gen3_en;
    end
  end

endmodule

// File: tb/tb_gen3_scrambler_ctrl.sv
// tb/tb_gen3_scrambler_ctrl.sv - directed self-checking bench for gen3_scrambler_ctrl
module tb_gen3_scrambler_ctrl;

  logic        pclk = 1'b0;
  logic        reset;
  logic        gen3_en;
  logic        beat_valid;
  logic        block_start;
  logic [1:0]  sync_hdr;
  logic [7:0]  beat_sym0;
  logic [23:0] seed_value;
  logic        scrambler_reset;
  logic        lfsr_advance;
  logic [3:0]  scramble_en;
  logic [2:0]  block_type;
  logic [1:0]  beat_idx;
  logic        sync_err;

  int passed = 0;
  int total  = 0;

  gen3_scrambler_ctrl #(.LANE_NUM(10)) dut (
    .pclk(pclk), .reset(reset), .gen3_en(gen3_en), .beat_valid(beat_valid),
    .block_start(block_start), .sync_hdr(sync_hdr), .beat_sym0(beat_sym0),
    .seed_value(seed_value), .scrambler_reset(scrambler_reset), .lfsr_advance(lfsr_advance),
    .scramble_en(scramble_en), .block_type(block_type), .beat_idx(beat_idx), .sync_err(sync_err)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // One beat per call; outputs are sampled 1 time unit after the capturing edge.
  task automatic drive(input logic v, input logic s, input logic [1:0] h, input logic [7:0] sym);
    @(negedge pclk);
    beat_valid  = v;
    block_start = s;
    sync_hdr    = h;
    beat_sym0   = sym;
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; gen3_en = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 2'b00, 8'h00);
    total++; if (block_type !== 3'd7) $display("FAIL rst_type got %0d want 7", block_type); else passed++;
    total++; if (scramble_en !== 4'h0) $display("FAIL rst_scr got %h want 0", scramble_en); else passed++;
    total++; if (scrambler_reset !== 1'b0) $display("FAIL rst_reload_during got %b want 0", scrambler_reset); else passed++;
    total++; if (seed_value !== 24'h1EC760) $display("FAIL seed got %h want 1EC760", seed_value); else passed++;
    reset = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 8'h00);
    total++; if (scrambler_reset !== 1'b1) $display("FAIL rst_reload_pulse got %b want 1", scrambler_reset); else passed++;
    total++; if (block_type !== 3'd7) $display("FAIL rst_type_after got %0d want 7", block_type); else passed++;
    drive(1'b0, 1'b0, 2'b00, 8'h00);
    total++; if (scrambler_reset !== 1'b0) $display("FAIL rst_reload_end got %b want 0", scrambler_reset); else passed++;
  endtask

  task automatic test_data();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, 2'b10, 8'h00);
      total++; if (beat_idx !== 2'(i)) $display("FAIL data_idx beat%0d got %0d want %0d", i, beat_idx, i); else passed++;
      total++; if (scramble_en !== 4'hF) $display("FAIL data_scr beat%0d got %h want F", i, scramble_en); else passed++;
      total++; if (lfsr_advance !== 1'b1) $display("FAIL data_adv beat%0d got %b want 1", i, lfsr_advance); else passed++;
      total++; if (sync_err !== 1'b0) $display("FAIL data_err beat%0d got %b want 0", i, sync_err); else passed++;
      total++; if (block_type !== 3'd0) $display("FAIL data_type beat%0d got %0d want 0", i, block_type); else passed++;
    end
  endtask

  task automatic test_ts_skp();
    logic [3:0] exp_scr;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, 2'b01, 8'h1E);
      exp_scr = (i == 0) ? 4'hE : 4'hF;
      total++; if (scramble_en !== exp_scr) $display("FAIL ts_scr beat%0d got %h want %h", i, scramble_en, exp_scr); else passed++;
      total++; if (lfsr_advance !== 1'b1) $display("FAIL ts_adv beat%0d got %b want 1", i, lfsr_advance); else passed++;
      total++; if (block_type !== 3'd1) $display("FAIL ts_type beat%0d got %0d want 1", i, block_type); else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, 2'b01, 8'hAA);
      total++; if (scramble_en !== 4'h0) $display("FAIL skp_scr beat%0d got %h want 0", i, scramble_en); else passed++;
      total++; if (lfsr_advance !== 1'b0) $display("FAIL skp_adv beat%0d got %b want 0", i, lfsr_advance); else passed++;
      total++; if (block_type !== 3'd2) $display("FAIL skp_type beat%0d got %0d want 2", i, block_type); else passed++;
      total++; if (sync_err !== 1'b0) $display("FAIL skp_err beat%0d got %b want 0", i, sync_err); else passed++;
    end
  endtask

  task automatic test_eieos();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, 2'b01, 8'h00);
      total++; if (lfsr_advance !== 1'b0) $display("FAIL eie_adv beat%0d got %b want 0", i, lfsr_advance); else passed++;
      total++; if (scramble_en !== 4'h0) $display("FAIL eie_scr beat%0d got %h want 0", i, scramble_en); else passed++;
      total++; if (scrambler_reset !== 1'b0) $display("FAIL eie_reload_early beat%0d got %b want 0", i, scrambler_reset); else passed++;
      total++; if (block_type !== 3'd3) $display("FAIL eie_type beat%0d got %0d want 3", i, block_type); else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, 2'b10, 8'h00);
      total++; if (scrambler_reset !== (i == 0)) $display("FAIL eie_reload beat%0d got %b want %b", i, scrambler_reset, i == 0); else passed++;
      total++; if (lfsr_advance !== 1'b1) $display("FAIL post_eie_adv beat%0d got %b want 1", i, lfsr_advance); else passed++;
    end
  endtask

  task automatic test_sync_err();
    drive(1'b1, 1'b1, 2'b10, 8'h00);
    drive(1'b1, 1'b0, 2'b10, 8'h00);
    drive(1'b1, 1'b1, 2'b10, 8'h00);
    total++; if (sync_err !== 1'b1) $display("FAIL early_start_err got %b want 1", sync_err); else passed++;
    total++; if (beat_idx !== 2'd0) $display("FAIL early_start_idx got %0d want 0", beat_idx); else passed++;
    drive(1'b1, 1'b0, 2'b10, 8'h00);
    total++; if (sync_err !== 1'b0) $display("FAIL early_start_err_clr got %b want 0", sync_err); else passed++;
    total++; if (beat_idx !== 2'd1) $display("FAIL early_start_idx1 got %0d want 1", beat_idx); else passed++;
    drive(1'b1, 1'b0, 2'b10, 8'h00);
    drive(1'b1, 1'b0, 2'b10, 8'h00);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, 2'b11, 8'h55);
      total++; if (sync_err !== (i == 0)) $display("FAIL badhdr_err beat%0d got %b want %b", i, sync_err, i == 0); else passed++;
      total++; if (scramble_en !== 4'h0) $display("FAIL badhdr_scr beat%0d got %h want 0", i, scramble_en); else passed++;
      total++; if (lfsr_advance !== 1'b1) $display("FAIL badhdr_adv beat%0d got %b want 1", i, lfsr_advance); else passed++;
      total++; if (block_type !== 3'd4) $display("FAIL badhdr_type beat%0d got %0d want 4", i, block_type); else passed++;
    end
    drive(1'b1, 1'b0, 2'b10, 8'h00);
    total++; if (sync_err !== 1'b1) $display("FAIL missing_start_err got %b want 1", sync_err); else passed++;
    total++; if (lfsr_advance !== 1'b0) $display("FAIL missing_start_adv got %b want 0", lfsr_advance); else passed++;
    drive(1'b1, 1'b0, 2'b10, 8'h00);
    total++; if (sync_err !== 1'b0) $display("FAIL hunt_err got %b want 0", sync_err); else passed++;
    total++; if (lfsr_advance !== 1'b0) $display("FAIL hunt_adv got %b want 0", lfsr_advance); else passed++;
  endtask

  task automatic test_gen3_toggle();
    gen3_en = 1'b0;
    drive(1'b1, 1'b1, 2'b10, 8'h00);
    total++; if (lfsr_advance !== 1'b0) $display("FAIL g3off_adv got %b want 0", lfsr_advance); else passed++;
    total++; if (scramble_en !== 4'h0) $display("FAIL g3off_scr got %h want 0", scramble_en); else passed++;
    gen3_en = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 8'h00);
    total++; if (scrambler_reset !== 1'b1) $display("FAIL g3rise_reload got %b want 1", scrambler_reset); else passed++;
    drive(1'b0, 1'b0, 2'b00, 8'h00);
    total++; if (scrambler_reset !== 1'b0) $display("FAIL g3rise_reload_end got %b want 0", scrambler_reset); else passed++;
    drive(1'b1, 1'b1, 2'b10, 8'h00);
    total++; if (lfsr_advance !== 1'b1) $display("FAIL g3on_adv got %b want 1", lfsr_advance); else passed++;
    total++; if (sync_err !== 1'b0) $display("FAIL g3on_err got %b want 0", sync_err); else passed++;
  endtask

  task automatic test_gap_reset();
    drive(1'b1, 1'b1, 2'b10, 8'h00);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 2'b10, 8'h00);
      total++; if (lfsr_advance !== 1'b0) $display("FAIL gap_adv cyc%0d got %b want 0", i, lfsr_advance); else passed++;
      total++; if (beat_idx !== 2'd0) $display("FAIL gap_idx cyc%0d got %0d want 0", i, beat_idx); else passed++;
      total++; if (block_type !== 3'd0) $display("FAIL gap_type cyc%0d got %0d want 0", i, block_type); else passed++;
    end
    drive(1'b1, 1'b0, 2'b10, 8'h00);
    total++; if (beat_idx !== 2'd1) $display("FAIL gap_resume_idx got %0d want 1", beat_idx); else passed++;
    total++; if (lfsr_advance !== 1'b1) $display("FAIL gap_resume_adv got %b want 1", lfsr_advance); else passed++;
    reset = 1'b1;
    drive(1'b1, 1'b0, 2'b10, 8'h00);
    total++; if (block_type !== 3'd7) $display("FAIL midrst_type got %0d want 7", block_type); else passed++;
    total++; if (lfsr_advance !== 1'b0) $display("FAIL midrst_adv got %b want 0", lfsr_advance); else passed++;
    reset = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 8'h00);
    total++; if (scrambler_reset !== 1'b1) $display("FAIL midrst_reload got %b want 1", scrambler_reset); else passed++;
    total++; if (lfsr_advance !== 1'b0) $display("FAIL midrst_hunt_adv got %b want 0", lfsr_advance); else passed++;
    total++; if (scramble_en !== 4'h0) $display("FAIL midrst_hunt_scr got %h want 0", scramble_en); else passed++;
    drive(1'b1, 1'b0, 2'b10, 8'h00);
    total++; if (scrambler_reset !== 1'b0) $display("FAIL midrst_reload_end got %b want 0", scrambler_reset); else passed++;
    total++; if (lfsr_advance !== 1'b0) $display("FAIL midrst_hunt_adv2 got %b want 0", lfsr_advance); else passed++;
  endtask

  initial begin
    reset = 1'b1; gen3_en = 1'b1; beat_valid = 1'b0; block_start = 1'b0;
    sync_hdr = 2'b00; beat_sym0 = 8'h00;
    test_reset();
    test_data();
    test_ts_skp();
    test_eieos();
    test_sync_err();
    test_gen3_toggle();
    test_gap_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
